// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the seven-segment scan scheduler.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package seg_scan_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic {
    BLANK,
    DRIVE
  } slot_state_e;

endpackage

// File: rtl/seg_scan_scheduler_hex_to_seg.sv
// Nibble to active-low seven-segment glyph.
// Pure lookup into the shared table.
import seg_scan_pkg::*;

module hex_to_seg (
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nib];

endmodule

// File: rtl/seg_scan_scheduler.sv
// Four-digit seven-segment scan scheduler with dead-time blanking.
// Optional: define LEADING_ZERO_BLANK_EN to hide leading zero digits.
import seg_scan_pkg::*;

module seg_scan_scheduler #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic [15:0] digits,
  input  logic [3:0]  digit_en,
  input  logic [3:0]  dp_sel,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_PRE   = CW'(SCAN_DIV - 2);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

  slot_state_e   state_q;
  slot_state_e   state_d;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;
  logic [1:0]    idx;
  logic [1:0]    idx_d;

  logic [15:0]   snap_digits;
  logic [3:0]    snap_en;
  logic [3:0]    snap_dp;

  logic [3:0]    vis;
  logic [3:0]    nib;
  logic [6:0]    dec;

  logic [6:0]    seg_d;
  logic          dp_d;
  logic [3:0]    an_d;
  logic          fd_d;

  assign nib = snap_digits[{idx, 2'b00} +: 4];

  hex_to_seg u_hex (
    .nib (nib),
    .seg (dec)
  );

`ifdef LEADING_ZERO_BLANK_EN
  assign vis[3] = snap_en[3] & (snap_digits[15:12] != 4'h0);
  assign vis[2] = snap_en[2] & (snap_digits[15:8] != 8'h0);
  assign vis[1] = snap_en[1] & (snap_digits[15:4] != 12'h0);
  assign vis[0] = snap_en[0];
`else
  assign vis = snap_en;
`endif

  // State tracks the slot phase of cnt, so it follows cnt_d.
  always_comb begin
    cnt_d = cnt + CW'(1);
    idx_d = idx;
    if (cnt == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx + 2'd1;
    end
    state_d = (cnt_d < CNT_BLANK) ? BLANK : DRIVE;
  end

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    fd_d  = (idx == 2'd3) && (cnt == CNT_PRE);
    if (state_q == DRIVE) begin
      seg_d = dec;
      dp_d  = ~snap_dp[idx];
      if (vis[idx]) begin
        an_d = ~(4'b0001 << idx);
      end
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (!reset) begin
      state_q     <= BLANK;
      cnt         <= '0;
      idx         <= '0;
      snap_digits <= '0;
      snap_en     <= '0;
      snap_dp     <= '0;
      an          <= AN_OFF;
      seg         <= SEG_OFF;
      dp          <= 1'b1;
      frame_done  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt        <= cnt_d;
      idx        <= idx_d;
      an         <= an_d;
      seg        <= seg_d;
      dp         <= dp_d;
      frame_done <= fd_d;
      if (cnt == '0 && idx == 2'd0) begin
        snap_digits <= digits;
        snap_en     <= digit_en;
        snap_dp     <= dp_sel;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Directed self-checking bench for seg_scan_scheduler.
// Runs with SCAN_DIV=8, BLANK_CYCLES=2.
module tb_seg_scan_scheduler;

  logic        clk;
  logic        reset;
  logic [15:0] digits;
  logic [3:0]  digit_en;
  logic [3:0]  dp_sel;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  seg_scan_scheduler #(
    .SCAN_DIV     (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk_100MHz (clk),
    .reset      (reset),
    .digits     (digits),
    .digit_en   (digit_en),
    .dp_sel     (dp_sel),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int n);
    while (cyc < n) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) begin
      tick();
      checks++;
      if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1 || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL rst_hold an=%b seg=%h dp=%b fd=%b want 1111/7f/1/0",
                 an, seg, dp, frame_done);
      end
    end
    reset = 1'b1;
    cyc = 0;
    for (int n = 1; n <= 2; n++) begin
      goto(n);
      checks++;
      if (an !== 4'b1111 || seg !== 7'h7F) begin
        errors++;
        $display("FAIL rel_dark cyc=%0d an=%b seg=%h want 1111/7f", cyc, an, seg);
      end
    end
    goto(3);
    checks++;
    if (an !== 4'b1110 || seg !== 7'h19) begin
      errors++;
      $display("FAIL rel_drive an=%b seg=%h want 1110/19", an, seg);
    end
  endtask

  task automatic test_scan();
    logic [3:0] ean [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] eseg [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
    logic       edp [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int s = 0; s < 4; s++) begin
      if (s > 0) begin
        goto(8 * s + 1);
        checks++;
        if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1) begin
          errors++;
          $display("FAIL scan_blank s=%0d an=%b seg=%h dp=%b want 1111/7f/1",
                   s, an, seg, dp);
        end
      end
      goto(8 * s + 3);
      checks++;
      if (an !== ean[s] || seg !== eseg[s] || dp !== edp[s]) begin
        errors++;
        $display("FAIL scan_drive s=%0d an=%b seg=%h dp=%b want %b/%h/%b",
                 s, an, seg, dp, ean[s], eseg[s], edp[s]);
      end
      goto(8 * s + 8);
      checks++;
      if (an !== ean[s]) begin
        errors++;
        $display("FAIL scan_hold s=%0d an=%b want %b", s, an, ean[s]);
      end
    end
  endtask

  task automatic test_frame_done();
    int pulses = 0;
    while (cyc < 96) begin
      tick();
      if (frame_done === 1'b1) pulses++;
      checks++;
      if (frame_done !== ((cyc % 32) == 31)) begin
        errors++;
        $display("FAIL frame_done cyc=%0d got=%b want=%b",
                 cyc, frame_done, (cyc % 32) == 31);
      end
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL fd_count got=%0d want=2", pulses);
    end
  endtask

  task automatic test_tear();
    goto(113);
    digits = 16'h5678;
    goto(115);
    checks++;
    if (an !== 4'b1011 || seg !== 7'h24 || dp !== 1'b0) begin
      errors++;
      $display("FAIL tear_s2 an=%b seg=%h dp=%b want 1011/24/0", an, seg, dp);
    end
    goto(123);
    checks++;
    if (an !== 4'b0111 || seg !== 7'h79) begin
      errors++;
      $display("FAIL tear_s3 an=%b seg=%h want 0111/79", an, seg);
    end
    goto(131);
    checks++;
    if (an !== 4'b1110 || seg !== 7'h00) begin
      errors++;
      $display("FAIL tear_next an=%b seg=%h want 1110/00", an, seg);
    end
  endtask

  task automatic test_digit_en();
    logic [3:0] exp;
    digit_en = 4'b1010;
    for (int s = 0; s < 4; s++) begin
      for (int c = 1; c <= 8; c++) begin
        goto(160 + 8 * s + c);
        exp = ((s % 2) == 1 && c >= 3) ? ~(4'b0001 << s) : 4'b1111;
        checks++;
        if (an !== exp) begin
          errors++;
          $display("FAIL digit_en s=%0d c=%0d an=%b want %b", s, c, an, exp);
        end
      end
    end
    digit_en = 4'hF;
    digits = 16'h0070;
  endtask

  task automatic test_lzb();
`ifdef LEADING_ZERO_BLANK_EN
    logic [3:0] ean [4] = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
`else
    logic [3:0] ean [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
`endif
    logic [6:0] eseg [4] = '{7'h40, 7'h78, 7'h40, 7'h40};
    for (int s = 0; s < 4; s++) begin
      goto(224 + 8 * s + 3);
      checks++;
      if (an !== ean[s] || seg !== eseg[s]) begin
        errors++;
        $display("FAIL lzb s=%0d an=%b seg=%h want %b/%h",
                 s, an, seg, ean[s], eseg[s]);
      end
    end
  endtask

  task automatic test_mid_reset();
    goto(273);
    digits = 16'h9ABC;
    goto(277);
    checks++;
    if (seg !== 7'h40) begin
      errors++;
      $display("FAIL mid_pre seg=%h want 40", seg);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1) begin
      errors++;
      $display("FAIL mid_dark an=%b seg=%h dp=%b want 1111/7f/1", an, seg, dp);
    end
    reset = 1'b1;
    cyc = 0;
    goto(3);
    checks++;
    if (an !== 4'b1110 || seg !== 7'h46) begin
      errors++;
      $display("FAIL mid_s0 an=%b seg=%h want 1110/46", an, seg);
    end
    goto(11);
    checks++;
    if (an !== 4'b1101 || seg !== 7'h03) begin
      errors++;
      $display("FAIL mid_s1 an=%b seg=%h want 1101/03", an, seg);
    end
  endtask

  initial begin
    reset    = 1'b0;
    digits   = 16'h1234;
    digit_en = 4'hF;
    dp_sel   = 4'b0100;
    test_reset();
    test_scan();
    test_frame_done();
    test_tear();
    test_digit_en();
    test_lzb();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
